// File: rtl/prog_loader_pkg.sv
// Shared definitions for the instruction-RAM loader.
package prog_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DATA  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam int DEF_ADDR_W     = 7;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/prog_loader_word_assembler.sv
// Packs stream bytes into 32-bit words, first byte landing in bits 31:24.
module word_assembler
  import prog_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  byte_in,
  input  logic        strobe,
  input  logic        clear,
  output logic [31:0] word,
  output logic        word_done
);

  // Only the first three bytes need storing; the fourth is taken straight
  // from the input on the completing strobe.
  logic [23:0] shift;
  logic [1:0]  phase;

  assign word      = {shift, byte_in};
  assign word_done = strobe && (phase == 2'(BYTES_PER_WORD - 1));

  // Byte shift register and position-within-word counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift <= '0;
      phase <= '0;
    end else if (clear) begin
      shift <= '0;
      phase <= '0;
    end else if (strobe) begin
      shift <= {shift[15:0], byte_in};
      phase <= phase + 2'd1;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Streams a counted byte payload into the instruction RAM from address 0.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int TIMEOUT   = 1024,
  parameter int DRAIN_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              iwen,
  output logic [ADDR_W-1:0] i_addr,
  output logic [31:0]       winst,
  output logic              wstb,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int NW = ADDR_W + 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam int DW = $clog2(DRAIN_CYC + 2);

  state_t          state, state_nx;
  logic [NW-1:0]   widx, n_words;
  logic [TW-1:0]   tcnt;
  logic [DW-1:0]   dcnt;
  logic            active, xfer, tmo, last_word, drain_end;
  logic            asm_stb, asm_clr, asm_done;
  logic [31:0]     asm_word;

  assign active    = (state == ST_COUNT) || (state == ST_DATA);
  assign rx_ready  = active;
  assign xfer      = rx_valid && active;
  assign tmo       = active && !xfer && (tcnt == TW'(TIMEOUT - 1));
  assign asm_stb   = xfer && (state == ST_DATA);
  assign asm_clr   = ((state == ST_IDLE) && start) || tmo;
  assign last_word = (state == ST_DATA) && asm_done && ((widx + NW'(1)) == n_words);
  assign drain_end = (state == ST_DRAIN) && (dcnt == DW'(DRAIN_CYC));
  // iwen tracks the session exactly: it rises on the start edge and falls
  // on the edge that returns to IDLE, so it is the registered state decoded.
  assign busy      = (state != ST_IDLE);
  assign iwen      = busy;

  word_assembler u_asm (
    .clk       (clk),
    .rst       (rst),
    .byte_in   (rx_data),
    .strobe    (asm_stb),
    .clear     (asm_clr),
    .word      (asm_word),
    .word_done (asm_done)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  // Next-state selection.
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:  if (start) state_nx = ST_COUNT;
      ST_COUNT: if (tmo) state_nx = ST_IDLE;
                else if (xfer) state_nx = ST_DATA;
      ST_DATA:  if (tmo) state_nx = ST_IDLE;
                else if (last_word) state_nx = ST_DRAIN;
      ST_DRAIN: if (drain_end) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Session counters, presented word and status pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      widx    <= '0;
      n_words <= '0;
      tcnt    <= '0;
      dcnt    <= '0;
      i_addr  <= '0;
      winst   <= '0;
      wstb    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      wstb <= 1'b0;
      done <= 1'b0;
      if (active) tcnt <= xfer ? '0 : tcnt + TW'(1);
      if (tmo) err <= 1'b1;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            err  <= 1'b0;
            widx <= '0;
            tcnt <= '0;
          end
        end
        ST_COUNT: begin
          if (xfer) n_words <= (rx_data == 8'd0) ? NW'(2**ADDR_W) : NW'(rx_data);
        end
        ST_DATA: begin
          if (asm_done) begin
            winst  <= asm_word;
            i_addr <= widx[ADDR_W-1:0];
            wstb   <= 1'b1;
            widx   <= widx + NW'(1);
          end
          if (last_word) dcnt <= '0;
        end
        ST_DRAIN: begin
          if (drain_end) done <= 1'b1;
          else           dcnt <= dcnt + DW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader.
module tb_prog_loader;

  localparam int ADDR_W = 7;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_ready, iwen, wstb, busy, done, err;
  logic [ADDR_W-1:0] i_addr;
  logic [31:0]       winst;

  prog_loader #(.ADDR_W(ADDR_W), .TIMEOUT(1024), .DRAIN_CYC(2)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .iwen(iwen), .i_addr(i_addr), .winst(winst),
    .wstb(wstb), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  // Observation record filled by the monitor.
  int unsigned       cyc = 0;
  logic [ADDR_W-1:0] got_a[$];
  logic [31:0]       got_w[$];
  int unsigned       done_cnt = 0, viol = 0, exp_n_mon = 0;
  int unsigned       last_wstb_cyc = 0, done_cyc = 0, fall_cyc = 0;
  logic              iwen_q = 1'b0, wstb_q = 1'b0, done_q = 1'b0;
  bit                in_drain = 0;

  bit [7:0] payload[$];

  typedef struct {
    logic [7:0]  cnt;
    int unsigned pat;
    int unsigned gap;
    bit          poke;
    int unsigned exp_n;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
  } vec_t;

  vec_t vecs[4];

  // Monitor: record presented words, pulses, and protocol violations.
  always @(negedge clk) begin
    cyc++;
    if (wstb) begin
      got_a.push_back(i_addr);
      got_w.push_back(winst);
      last_wstb_cyc = cyc;
      if (got_w.size() == exp_n_mon) in_drain = 1;
    end
    if (!busy) in_drain = 0;
    if (rx_ready && (!busy || in_drain)) viol++;
    if (iwen != busy) viol++;
    if (wstb && wstb_q) viol++;
    if (done && done_q) viol++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (iwen_q && !iwen) fall_cyc = cyc;
    iwen_q = iwen;
    wstb_q = wstb;
    done_q = done;
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int unsigned n = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && n < 20) begin
      tick();
      n++;
    end
    if (!rx_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_byte: rx_ready stayed 0 for byte %0h, expected 1", b);
    end
    tick();
  endtask

  task automatic wait_idle(input string nm, input int unsigned lim);
    int unsigned n = 0;
    while (busy && n < lim) begin
      tick();
      n++;
    end
    chk({nm, " idle"}, 32'(busy), 32'd0);
  endtask

  task automatic clear_obs(input int unsigned n);
    got_a.delete();
    got_w.delete();
    done_cnt  = 0;
    viol      = 0;
    exp_n_mon = n;
  endtask

  // Full session: counted payload, checked against the byte-packing rule.
  task automatic run_session(input logic [7:0] cnt, input int unsigned gap,
                             input bit poke, input string nm);
    int unsigned n;
    int unsigned lat_bad = 0;
    logic [31:0] ew;
    n = (cnt == 8'd0) ? 128 : int'(cnt);
    clear_obs(n);
    start = 1'b1; rx_valid = 1'b1; rx_data = 8'hEE;
    tick();
    start = 1'b0; rx_valid = 1'b0;
    chk({nm, " iwen after start"}, 32'(iwen), 32'd1);
    chk({nm, " err after start"}, 32'(err), 32'd0);
    send_byte(cnt);
    for (int i = 0; i < payload.size(); i++) begin
      if (poke && i == 5) start = 1'b1;
      send_byte(payload[i]);
      start = 1'b0;
      if (i % 4 == 3 && !wstb) lat_bad++;
      if (gap == 1 || (gap == 2 && $urandom_range(0, 1) == 1)) begin
        rx_valid = 1'b0;
        tick();
      end
    end
    rx_valid = 1'b0;
    wait_idle(nm, 20);
    chk({nm, " word count"}, 32'(got_w.size()), 32'(n));
    for (int k = 0; k < got_w.size() && k < n; k++) begin
      ew = {payload[4*k], payload[4*k+1], payload[4*k+2], payload[4*k+3]};
      chk($sformatf("%s addr[%0d]", nm, k), 32'(got_a[k]), 32'(k));
      chk($sformatf("%s word[%0d]", nm, k), got_w[k], ew);
    end
    chk({nm, " done pulses"}, done_cnt, 32'd1);
    chk({nm, " err"}, 32'(err), 32'd0);
    chk({nm, " iwen end"}, 32'(iwen), 32'd0);
    chk({nm, " protocol viol"}, viol, 32'd0);
    chk({nm, " wstb latency"}, lat_bad, 32'd0);
    chk({nm, " drain cycles"}, fall_cyc - last_wstb_cyc, 32'd3);
    chk({nm, " done with iwen fall"}, done_cyc, fall_cyc);
  endtask

  task automatic build_payload(input int unsigned pat, input int unsigned n);
    payload.delete();
    if (pat == 0) begin
      payload = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    end else if (pat == 1) begin
      for (int i = 0; i < 4 * n; i++) payload.push_back(8'(i));
    end else begin
      for (int i = 0; i < 4 * n; i++) payload.push_back(8'($urandom));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'd2, 0, 0, 1'b0, 2,   32'h13050000, 32'h93051000};
    vecs[1] = '{8'd0, 1, 0, 1'b0, 128, 32'h00010203, 32'hFCFDFEFF};
    vecs[2] = '{8'd2, 0, 1, 1'b1, 2,   32'h13050000, 32'h93051000};
    vecs[3] = '{8'd3, 1, 2, 1'b1, 3,   32'h00010203, 32'h08090A0B};

    // Reset values.
    tick(); tick();
    chk("rst rx_ready", 32'(rx_ready), 32'd0);
    chk("rst iwen",     32'(iwen),     32'd0);
    chk("rst i_addr",   32'(i_addr),   32'd0);
    chk("rst winst",    winst,         32'd0);
    chk("rst wstb",     32'(wstb),     32'd0);
    chk("rst busy",     32'(busy),     32'd0);
    chk("rst done",     32'(done),     32'd0);
    chk("rst err",      32'(err),      32'd0);
    rst = 1'b1;
    tick();

    // Directed table.
    for (int v = 0; v < 4; v++) begin
      build_payload(vecs[v].pat, vecs[v].exp_n);
      run_session(vecs[v].cnt, vecs[v].gap, vecs[v].poke, $sformatf("vec%0d", v));
      if (got_w.size() > 0) begin
        chk($sformatf("vec%0d first word", v), got_w[0], vecs[v].exp_first);
        chk($sformatf("vec%0d last word", v), got_w[got_w.size()-1], vecs[v].exp_last);
        chk($sformatf("vec%0d last addr", v), 32'(got_a[got_a.size()-1]), vecs[v].exp_n - 1);
      end else begin
        chk($sformatf("vec%0d words seen", v), 32'd0, vecs[v].exp_n);
      end
      tick();
    end

    // Randomized sessions.
    for (int r = 0; r < 6; r++) begin
      int unsigned n;
      n = $urandom_range(1, 12);
      build_payload(2, n);
      run_session(8'(n), $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                  $sformatf("rnd%0d", r));
      tick();
    end

    // Timeout mid-word.
    clear_obs(1);
    start = 1'b1; tick(); start = 1'b0;
    send_byte(8'd1);
    send_byte(8'hAA);
    send_byte(8'hBB);
    rx_valid = 1'b0;
    for (int i = 0; i < 1000; i++) tick();
    chk("tmo busy before limit", 32'(busy), 32'd1);
    chk("tmo err before limit",  32'(err),  32'd0);
    wait_idle("tmo", 100);
    chk("tmo err",      32'(err),           32'd1);
    chk("tmo iwen",     32'(iwen),          32'd0);
    chk("tmo no wstb",  32'(got_w.size()),  32'd0);
    chk("tmo no done",  done_cnt,           32'd0);
    tick(); tick();
    chk("tmo err sticky", 32'(err), 32'd1);
    build_payload(2, 1);
    run_session(8'd1, 0, 1'b0, "after_tmo");
    tick();

    // Asynchronous reset mid-session.
    clear_obs(3);
    start = 1'b1; tick(); start = 1'b0;
    send_byte(8'd3);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h55);
    chk("prerst winst",  winst,        32'h11223344);
    chk("prerst busy",   32'(busy),    32'd1);
    #1 rst = 1'b0;
    #1;
    chk("arst rx_ready", 32'(rx_ready), 32'd0);
    chk("arst iwen",     32'(iwen),     32'd0);
    chk("arst i_addr",   32'(i_addr),   32'd0);
    chk("arst winst",    winst,         32'd0);
    chk("arst wstb",     32'(wstb),     32'd0);
    chk("arst busy",     32'(busy),     32'd0);
    chk("arst done",     32'(done),     32'd0);
    chk("arst err",      32'(err),      32'd0);
    rx_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("arst no done", done_cnt, 32'd0);
    build_payload(2, 2);
    run_session(8'd2, 0, 1'b0, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Upstream feeder for the chip's instruction-load port.
- Accepts a byte stream over a valid/ready handshake and assembles 32-bit instruction words.
- Drives iwen/i_addr/winst so the instruction RAM is filled from address 0, then releases iwen so the core starts fetching.
- Byte order matches the core's fetch swap: first stream byte (instruction bits 7:0) lands in winst[31:24].

Parameters:
ADDR_W, 7, instruction RAM word-address width (depth 2**ADDR_W = 128)
TIMEOUT, 1024, idle cycles allowed between accepted bytes mid-session before abort
DRAIN_CYC, 2, cycles iwen stays high after the last word is presented

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a load session (ignored unless IDLE)
rx_valid  in  1  byte available on rx_data
rx_data  in  8  stream byte
rx_ready  out  1  loader accepts byte this cycle (transfer = rx_valid & rx_ready)
iwen  out  1  load-mode enable to chip; high for whole session
i_addr  out  ADDR_W  word address of presented word
winst  out  32  presented instruction word (stored byte order)
wstb  out  1  one-cycle pulse: new word valid on i_addr/winst
busy  out  1  session in progress (any state except IDLE)
done  out  1  one-cycle pulse on successful completion
err  out  1  sticky timeout flag; cleared by next accepted start

Behaviour:
- Async reset (rst=0): state IDLE; iwen, i_addr, winst, wstb, busy, done, err, rx_ready, all counters = 0.
- States: IDLE, COUNT, DATA, DRAIN.
- IDLE: rx_ready=0. start=1 -> COUNT, err<=0, word index<=0, byte phase<=0, timeout counter<=0, iwen<=1 on same edge.
- COUNT: rx_ready=1. First accepted byte = word count N; 0 means 2**ADDR_W. -> DATA.
- DATA: rx_ready=1. Each accepted byte: shift <= {shift[23:0], rx_data}; byte phase increments mod 4.
- On the 4th byte of a word (registered, visible the next cycle): winst <= completed word, i_addr <= word index, wstb=1 for exactly one cycle; word index increments.
- winst/i_addr hold until the next word completes.
- After word N is presented -> DRAIN; rx_ready=0 from that cycle on.
- DRAIN: count DRAIN_CYC cycles; then iwen<=0, done=1 for one cycle, -> IDLE. i_addr/winst keep the last word.
- Timeout: counter increments each cycle in COUNT/DATA without a transfer and clears on a transfer. When it reaches TIMEOUT-1: iwen<=0, err<=1, -> IDLE, partial word discarded, done not pulsed.
- start while busy: ignored. start coincident with rx_valid in IDLE: byte not accepted (rx_ready=0 in IDLE).
- Index arithmetic is ADDR_W+1 bits so N=128 terminates without wrap. i_addr never exceeds 2**ADDR_W-1.
- rst asserted mid-session: immediate return to reset values; no done, no err.
- Latency: accept of 4th byte -> wstb next cycle. Last wstb -> iwen fall after DRAIN_CYC+1 cycles, same edge as done.

Decomposition:
- Shared package: ST_IDLE/ST_COUNT/ST_DATA/ST_DRAIN state encoding, ADDR_W default, BYTES_PER_WORD=4.
- One sub-module: word_assembler (shift register plus 2-bit byte phase; inputs: byte, strobe, clear; outputs: word, word_done).

Test Plan:
- Reset then start, count=2, bytes 13 05 00 00 93 05 10 00 -> wstb at i_addr 0 winst 32'h13050000, wstb at i_addr 1 winst 32'h93051000; iwen falls 3 cycles after second wstb; done=1 for one cycle; err=0.
- Count byte 0x00, 512 bytes of incrementing values -> 128 wstb pulses, i_addr 0..127, last winst 32'hFCFDFEFF; no wrap; done=1.
- Count=1, send 2 bytes, then stall 1024 cycles -> err=1, iwen=0, no wstb, no done; next start clears err.
- rx_valid held with gaps (valid toggling every other cycle) and start pulsed mid-session -> assembled words unchanged; start ignored; rx_ready=0 in IDLE and DRAIN.
- Assert rst after 5 bytes of a count=3 session -> all outputs 0 immediately (async); a later full session loads correctly from address 0.
